// File: rtl/usb_nrzi_encoder.sv
// USB full-speed transmitter: SYNC, LSB-first payload and EOP, NRZI-encoded onto D+/D-.
// Define BIT_STUFF_EN to insert a stuffed 0 after every six consecutive raw 1s.
module usb_nrzi_encoder #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       tx_ack,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_busy
);

`ifdef BIT_STUFF_EN
    localparam bit StuffEn = 1'b1;
`else
    localparam bit StuffEn = 1'b0;
`endif

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StSync, StData, StEop} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [6:0]      shift_q, shift_d;
    logic [2:0]      ones_q, ones_d;
    logic            line_q, line_d;
    logic            dp_q, dp_d;
    logic            dm_q, dm_d;

    logic bit_end, need_stuff, byte_end, send_raw, raw_bit;

    assign bit_end    = (state_q != StIdle) && (cnt_q == CntMax);
    assign need_stuff = StuffEn && (ones_q == 3'd6);
    // A pending stuffed bit belongs to the current byte, so the boundary waits for it.
    assign byte_end   = (idx_q == 3'd7) && !need_stuff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            ones_q  <= '0;
            line_q  <= 1'b1;
            dp_q    <= 1'b1;
            dm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            ones_q  <= ones_d;
            line_q  <= line_d;
            dp_q    <= dp_d;
            dm_q    <= dm_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        ones_d   = ones_q;
        line_d   = line_q;
        dp_d     = dp_q;
        dm_d     = dm_q;
        send_raw = 1'b0;
        raw_bit  = 1'b0;
        cnt_d    = (state_q == StIdle || bit_end) ? '0 : cnt_q + 1'b1;

        case (state_q)
            StIdle: begin
                line_d = 1'b1;
                dp_d   = 1'b1;
                dm_d   = 1'b0;
                if (tx_start) begin
                    state_d  = StSync;
                    idx_d    = '0;
                    ones_d   = '0;
                    send_raw = 1'b1;
                end
            end
            StSync, StData: begin
                if (bit_end) begin
                    if (need_stuff) begin
                        send_raw = 1'b1;
                    end else if (byte_end) begin
                        idx_d = '0;
                        if (tx_valid) begin
                            state_d  = StData;
                            shift_d  = tx_byte[7:1];
                            send_raw = 1'b1;
                            raw_bit  = tx_byte[0];
                        end else begin
                            state_d = StEop;
                            line_d  = 1'b1;
                            dp_d    = 1'b0;
                            dm_d    = 1'b0;
                        end
                    end else begin
                        idx_d    = idx_q + 3'd1;
                        send_raw = 1'b1;
                        if (state_q == StSync) begin
                            raw_bit = (idx_q == 3'd6);
                        end else begin
                            raw_bit = shift_q[0];
                            shift_d = shift_q >> 1;
                        end
                    end
                end
            end
            StEop: begin
                if (bit_end) begin
                    if (idx_q == 3'd2) begin
                        state_d = StIdle;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        if (idx_q == 3'd1) begin
                            dp_d = 1'b1;
                            dm_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // NRZI: a raw 0 flips J/K, a raw 1 holds the line.
        if (send_raw) begin
            line_d = raw_bit ? line_q : ~line_q;
            ones_d = raw_bit ? ((ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1) : 3'd0;
            dp_d   = line_d;
            dm_d   = ~line_d;
        end
    end

    always_comb begin
        tx_ack  = (state_q == StSync || state_q == StData) && bit_end && byte_end && tx_valid;
        tx_busy = (state_q != StIdle);
        d_plus  = dp_q;
        d_minus = dm_q;
    end

endmodule

// File: tb/tb_usb_nrzi_encoder.sv
// Scoreboard bench for usb_nrzi_encoder: a bench-side NRZI/stuffing model fills expected
// line symbols and tx_ack cycles; the captured line is checked once per bit time.
module tb_usb_nrzi_encoder;
    localparam int Cpb = 8;
    localparam logic [1:0] SymJ = 2'b10;
    localparam logic [1:0] SymK = 2'b01;
    localparam logic [1:0] SymSe0 = 2'b00;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ack;
    logic       d_plus;
    logic       d_minus;
    logic       tx_busy;

    always #5 clk = ~clk;

    usb_nrzi_encoder #(.CLKS_PER_BIT(Cpb)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start),
        .tx_byte  (tx_byte),
        .tx_valid (tx_valid),
        .tx_ack   (tx_ack),
        .d_plus   (d_plus),
        .d_minus  (d_minus),
        .tx_busy  (tx_busy)
    );

    int n_vec = 0;
    int n_fail = 0;

    logic [7:0] tx_bytes[$];
    logic [1:0] exp_sym[$];
    int         exp_ack[$];
    logic [1:0] obs_sym[$];
    int         obs_ack[$];
    int         busy_cyc, glitches, late_busy;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: raw bit stream, optional stuffing, NRZI and EOP.
    task automatic build_expected();
        logic       raw[$];
        logic [1:0] line;
        int         ones;
        int         bitpos;
        logic       b;
        exp_sym.delete();
        exp_ack.delete();
        for (int i = 0; i < 7; i++) raw.push_back(1'b0);
        raw.push_back(1'b1);
        ones = 1;
        bitpos = 8;
        foreach (tx_bytes[k]) begin
            exp_ack.push_back(bitpos * Cpb - 1);
            for (int i = 0; i < 8; i++) begin
                b = tx_bytes[k][i];
                raw.push_back(b);
                bitpos++;
                ones = b ? ones + 1 : 0;
`ifdef BIT_STUFF_EN
                if (ones == 6) begin
                    raw.push_back(1'b0);
                    bitpos++;
                    ones = 0;
                end
`endif
            end
        end
        line = SymJ;
        foreach (raw[i]) begin
            if (!raw[i]) line = (line == SymJ) ? SymK : SymJ;
            exp_sym.push_back(line);
        end
        exp_sym.push_back(SymSe0);
        exp_sym.push_back(SymSe0);
        exp_sym.push_back(SymJ);
    endtask

    // Sends tx_bytes as one packet and records what the DUT put on the line.
    task automatic drive_packet(input bit restart);
        int         k;
        bit         ackd;
        logic [1:0] prev, sym;
        obs_sym.delete();
        obs_ack.delete();
        busy_cyc = 0;
        glitches = 0;
        @(negedge clk);
        tx_start = 1'b1;
        tx_valid = 1'b1;
        tx_byte  = tx_bytes[0];
        k = 0;
        @(posedge clk);
        #1 tx_start = 1'b0;
        prev = {d_plus, d_minus};
        for (int c = 0; c < 64 * Cpb; c++) begin
            @(negedge clk);
            sym = {d_plus, d_minus};
            if (sym != prev && (c % Cpb) != 0) glitches++;
            prev = sym;
            if (!tx_busy) break;
            busy_cyc++;
            if ((c % Cpb) == Cpb / 2) obs_sym.push_back(sym);
            ackd = tx_ack;
            if (ackd) obs_ack.push_back(c);
            @(posedge clk);
            #1;
            if (ackd) begin
                k++;
                if (k < tx_bytes.size()) tx_byte = tx_bytes[k];
                else begin
                    tx_valid = 1'b0;
                    tx_byte  = 8'h00;
                end
            end
            if (restart) tx_start = (c >= 12 * Cpb) && (c < 12 * Cpb + 20);
        end
        tx_start = 1'b0;
        tx_valid = 1'b0;
        late_busy = 0;
        repeat (5 * Cpb) begin
            @(negedge clk);
            if (tx_busy || tx_ack) late_busy++;
            if ({d_plus, d_minus} != SymJ) late_busy++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_start = 1'b0;
        tx_valid = 1'b0;
        tx_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({d_plus, d_minus, tx_busy, tx_ack} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_outputs: got dp/dm/busy/ack=%b, want 1000",
                     {d_plus, d_minus, tx_busy, tx_ack});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_vec++;
        if ({d_plus, d_minus, tx_busy, tx_ack} !== 4'b1000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got dp/dm/busy/ack=%b, want 1000",
                     {d_plus, d_minus, tx_busy, tx_ack});
        end
    endtask

    task automatic test_single_zero();
        tx_bytes = '{8'h00};
        build_expected();
        drive_packet(1'b0);
        n_vec++;
        if (obs_sym.size() !== exp_sym.size()) begin
            n_fail++;
            $display("FAIL zero_len: got %0d bit times, want %0d", obs_sym.size(), exp_sym.size());
        end
        for (int i = 0; obs_sym.size() > 0 && exp_sym.size() > 0; i++) begin
            n_vec++;
            if (obs_sym[0] !== exp_sym[0]) begin
                n_fail++;
                $display("FAIL zero_line bit %0d: got %b, want %b", i, obs_sym[0], exp_sym[0]);
            end
            void'(obs_sym.pop_front());
            void'(exp_sym.pop_front());
        end
        n_vec++;
        if (busy_cyc !== 152) begin
            n_fail++;
            $display("FAIL zero_busy: got %0d cycles, want 152", busy_cyc);
        end
        n_vec++;
        if (obs_ack.size() !== 1 || obs_ack[0] !== exp_ack[0]) begin
            n_fail++;
            $display("FAIL zero_ack: got %0d acks (first at %0d), want 1 at %0d",
                     obs_ack.size(), (obs_ack.size() > 0) ? obs_ack[0] : -1, exp_ack[0]);
        end
        n_vec++;
        if (glitches !== 0 || late_busy !== 0) begin
            n_fail++;
            $display("FAIL zero_quiet: got %0d mid-bit edges, %0d idle faults, want 0 and 0",
                     glitches, late_busy);
        end
    endtask

    task automatic test_all_ones();
        int want_busy;
`ifdef BIT_STUFF_EN
        want_busy = 160;
`else
        want_busy = 152;
`endif
        tx_bytes = '{8'hFF};
        build_expected();
        drive_packet(1'b0);
        n_vec++;
        if (obs_sym.size() !== exp_sym.size()) begin
            n_fail++;
            $display("FAIL ones_len: got %0d bit times, want %0d", obs_sym.size(), exp_sym.size());
        end
        for (int i = 0; obs_sym.size() > 0 && exp_sym.size() > 0; i++) begin
            n_vec++;
            if (obs_sym[0] !== exp_sym[0]) begin
                n_fail++;
                $display("FAIL ones_line bit %0d: got %b, want %b", i, obs_sym[0], exp_sym[0]);
            end
            void'(obs_sym.pop_front());
            void'(exp_sym.pop_front());
        end
        n_vec++;
        if (busy_cyc !== want_busy) begin
            n_fail++;
            $display("FAIL ones_busy: got %0d cycles, want %0d", busy_cyc, want_busy);
        end
        n_vec++;
        if (obs_ack.size() !== 1 || glitches !== 0) begin
            n_fail++;
            $display("FAIL ones_ack: got %0d acks, %0d mid-bit edges, want 1 and 0",
                     obs_ack.size(), glitches);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want[3];
        logic [7:0] dec[3];
        logic [1:0] prev;
        want[0] = 8'h3C;
        want[1] = 8'hA5;
        want[2] = 8'h80;
        tx_bytes = '{8'h3C, 8'hA5, 8'h80};
        build_expected();
        drive_packet(1'b0);
        n_vec++;
        if (busy_cyc !== 280) begin
            n_fail++;
            $display("FAIL b2b_busy: got %0d cycles, want 280", busy_cyc);
        end
        n_vec++;
        if (obs_ack.size() !== 3) begin
            n_fail++;
            $display("FAIL b2b_ack_count: got %0d, want 3", obs_ack.size());
        end
        for (int i = 0; i < 3 && i < obs_ack.size(); i++) begin
            n_vec++;
            if (obs_ack[i] !== exp_ack[i]) begin
                n_fail++;
                $display("FAIL b2b_ack_cycle %0d: got %0d, want %0d", i, obs_ack[i], exp_ack[i]);
            end
            if (i > 0) begin
                n_vec++;
                if (obs_ack[i] - obs_ack[i-1] !== 64) begin
                    n_fail++;
                    $display("FAIL b2b_ack_gap %0d: got %0d cycles, want 64", i,
                             obs_ack[i] - obs_ack[i-1]);
                end
            end
        end
        // NRZI-decode the captured line back into payload bytes.
        dec[0] = 8'h00;
        dec[1] = 8'h00;
        dec[2] = 8'h00;
        prev = SymJ;
        for (int i = 0; i < 32 && i < obs_sym.size(); i++) begin
            if (i >= 8) dec[(i - 8) / 8][(i - 8) % 8] = (obs_sym[i] == prev);
            prev = obs_sym[i];
        end
        for (int j = 0; j < 3; j++) begin
            n_vec++;
            if (dec[j] !== want[j]) begin
                n_fail++;
                $display("FAIL b2b_decode byte %0d: got %h, want %h", j, dec[j], want[j]);
            end
        end
        for (int i = 0; obs_sym.size() > 0 && exp_sym.size() > 0; i++) begin
            n_vec++;
            if (obs_sym[0] !== exp_sym[0]) begin
                n_fail++;
                $display("FAIL b2b_line bit %0d: got %b, want %b", i, obs_sym[0], exp_sym[0]);
            end
            void'(obs_sym.pop_front());
            void'(exp_sym.pop_front());
        end
    endtask

    task automatic test_restart_ignored();
        tx_bytes = '{8'h55};
        build_expected();
        drive_packet(1'b1);
        n_vec++;
        if (busy_cyc !== 152 || obs_ack.size() !== 1) begin
            n_fail++;
            $display("FAIL restart_packet: got %0d busy cycles, %0d acks, want 152 and 1",
                     busy_cyc, obs_ack.size());
        end
        n_vec++;
        if (late_busy !== 0) begin
            n_fail++;
            $display("FAIL restart_second_packet: got %0d idle faults, want 0", late_busy);
        end
    endtask

    task automatic test_reset_mid_data();
        int bad;
        @(negedge clk);
        tx_start = 1'b1;
        tx_valid = 1'b1;
        tx_byte  = 8'hAA;
        @(posedge clk);
        #1 tx_start = 1'b0;
        repeat (11 * Cpb + 2) @(posedge clk);
        #2;
        n_vec++;
        if (tx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre_busy: got %b, want 1", tx_busy);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({d_plus, d_minus, tx_busy, tx_ack} !== 4'b1000) begin
            n_fail++;
            $display("FAIL midrst_outputs: got dp/dm/busy/ack=%b, want 1000",
                     {d_plus, d_minus, tx_busy, tx_ack});
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (10 * Cpb) begin
            @(negedge clk);
            if (tx_ack || tx_busy || {d_plus, d_minus} != SymJ) bad++;
        end
        tx_valid = 1'b0;
        n_vec++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL midrst_after: got %0d active cycles, want 0", bad);
        end
        tx_bytes = '{8'h00};
        build_expected();
        drive_packet(1'b0);
        n_vec++;
        if (busy_cyc !== 152 || obs_ack.size() !== 1 || obs_sym[0] !== exp_sym[0]) begin
            n_fail++;
            $display("FAIL midrst_resume: got %0d busy cycles, %0d acks, want 152 and 1",
                     busy_cyc, obs_ack.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_zero();
        test_all_ones();
        test_back_to_back();
        test_restart_ignored();
        test_reset_mid_data();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
